// File: rtl/simmem_pkg.sv
// Shared defaults and types for the simulated-memory ID list bank.
package simmem_pkg;

    localparam int unsigned DefaultStructWidth   = 64;
    localparam int unsigned DefaultTotalCapacity = 64;
    localparam int unsigned DefaultIDWidth       = 4;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } simmem_arb_e;

endpackage

// File: rtl/simmem_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index and valid flag.
module simmem_prio_enc #(
    parameter int unsigned Width = 8,
    localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] req_i,
    output logic [Width-1:0] onehot_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    assign onehot_o = req_i & (~req_i + Width'(1));
    assign valid_o  = |req_i;

    always_comb begin
        idx_o = '0;
        for (int unsigned i = Width; i > 0; i--) begin
            if (req_i[i-1]) idx_o = IdxW'(i - 1);
        end
    end

endmodule

// File: rtl/simmem_id_list_bank.sv
// Per-ID linked-list store over one shared entry pool with a registered output stage.
// Define SIMMEM_RR_RELEASE_EN for round-robin release arbitration (default: fixed priority).
module simmem_id_list_bank
    import simmem_pkg::*;
#(
    parameter int unsigned StructWidth   = DefaultStructWidth,
    parameter int unsigned TotalCapacity = DefaultTotalCapacity,
    parameter int unsigned IDWidth       = DefaultIDWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [2**IDWidth-1:0]              release_en_i,
    input  logic [StructWidth-1:0]             data_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    output logic [StructWidth-1:0]             data_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [2**IDWidth-1:0]              id_nonempty_o,
    output logic [$clog2(TotalCapacity+1)-1:0] free_cnt_o
);

    localparam int unsigned NumIds = 2**IDWidth;
    localparam int unsigned AddrW  = $clog2(TotalCapacity);
    localparam int unsigned CntW   = $clog2(TotalCapacity + 1);
    localparam int unsigned PayW   = StructWidth - IDWidth;

    logic [PayW-1:0]          payload_q [TotalCapacity];
    logic [AddrW-1:0]         next_q    [TotalCapacity];
    logic [TotalCapacity-1:0] alloc_q, alloc_d;
    logic [AddrW-1:0]         head_q [NumIds], head_d [NumIds];
    logic [AddrW-1:0]         tail_q [NumIds], tail_d [NumIds];
    logic [CntW-1:0]          cnt_q  [NumIds], cnt_d  [NumIds];
    logic [CntW-1:0]          free_cnt_q, free_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [StructWidth-1:0]   data_q, data_d;

    logic [TotalCapacity-1:0] free_oh;
    logic [AddrW-1:0]         free_idx;
    logic                     free_valid;

    logic [NumIds-1:0]        cand, rot_req, rot_oh, sel_oh;
    logic [IDWidth-1:0]       rot_idx, sel_id;
    logic                     id_valid;

    logic                     push, pop;
    logic [IDWidth-1:0]       push_id;
    logic [AddrW-1:0]         pop_head;

    assign in_ready_o  = (free_cnt_q != '0);
    assign free_cnt_o  = free_cnt_q;
    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;

    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) id_nonempty_o[i] = (cnt_q[i] != '0);
    end

    assign push     = in_valid_i && in_ready_o;
    assign push_id  = data_i[IDWidth-1:0];
    assign cand     = release_en_i & id_nonempty_o;
    assign pop      = id_valid && (!out_valid_q || out_ready_i);
    assign pop_head = head_q[sel_id];

    simmem_prio_enc #(.Width(TotalCapacity)) u_free_enc (
        .req_i    (~alloc_q),
        .onehot_o (free_oh),
        .idx_o    (free_idx),
        .valid_o  (free_valid)
    );

    simmem_prio_enc #(.Width(NumIds)) u_id_enc (
        .req_i    (rot_req),
        .onehot_o (rot_oh),
        .idx_o    (rot_idx),
        .valid_o  (id_valid)
    );

`ifdef SIMMEM_RR_RELEASE_EN
    localparam simmem_arb_e ArbMode = ARB_RR;

    logic [IDWidth-1:0] last_q;
    logic [IDWidth-1:0] rr_start;

    // Rotate so bit 0 is the ID just above the last grant, then rotate the grant back.
    assign rr_start = last_q + IDWidth'(1);
    assign rot_req  = NumIds'({cand, cand} >> rr_start);
    assign sel_oh   = NumIds'(({rot_oh, rot_oh} << rr_start) >> NumIds);
    assign sel_id   = rot_idx + rr_start;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  last_q <= '1;
        else if (pop) last_q <= sel_id;
    end
`else
    localparam simmem_arb_e ArbMode = ARB_FIXED;

    assign rot_req = cand;
    assign sel_oh  = rot_oh;
    assign sel_id  = rot_idx;
`endif

    always_comb begin
        alloc_d    = alloc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        free_cnt_d = free_cnt_q - CntW'(push) + CntW'(pop);
        if (pop) begin
            alloc_d[pop_head] = 1'b0;
            if (cnt_q[sel_id] != CntW'(1)) head_d[sel_id] = next_q[pop_head];
        end
        if (push) begin
            alloc_d         = alloc_d | free_oh;
            tail_d[push_id] = free_idx;
            // A same-ID pop emptying a single-entry list hands the head to the new entry.
            if (cnt_q[push_id] == '0 ||
                (pop && sel_id == push_id && cnt_q[push_id] == CntW'(1)))
                head_d[push_id] = free_idx;
        end
        for (int unsigned i = 0; i < NumIds; i++) begin
            cnt_d[i] = cnt_q[i] + CntW'(push && push_id == IDWidth'(i))
                                - CntW'(pop && sel_oh[i]);
        end
    end

    always_comb begin
        data_d      = data_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            data_d      = {payload_q[pop_head], sel_id};
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q     <= '0;
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
            cnt_q       <= '{default: '0};
            free_cnt_q  <= CntW'(TotalCapacity);
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            alloc_q     <= alloc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            free_cnt_q  <= free_cnt_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            payload_q[free_idx] <= data_i[StructWidth-1:IDWidth];
            if (cnt_q[push_id] != '0) next_q[tail_q[push_id]] <= free_idx;
        end
    end

    logic [31:0] occ_sum;
    always_comb begin
        occ_sum = 32'(free_cnt_q);
        for (int unsigned i = 0; i < NumIds; i++) occ_sum = occ_sum + 32'(cnt_q[i]);
    end

    a_occupancy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        occ_sum == 32'(TotalCapacity));
    a_free_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_ready_o == free_valid);
    a_fixed_prio: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ArbMode == ARB_FIXED && pop) |-> ((cand & (sel_oh - NumIds'(1))) == '0));
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(data_o)));

endmodule
